// File: rtl/uart_rx_word_packer_if.sv
// Byte-side and word-side handshake bundle for the UART receive word packer.
// master drives bytes in and pops words; slave is the packer itself.
interface uart_rx_word_packer_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        flush;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;

  modport master (
    output byte_valid,
    output byte_data,
    output flush,
    output word_ready,
    input  word_valid,
    input  word_data
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    input  flush,
    input  word_ready,
    output word_valid,
    output word_data
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes little-endian into 32-bit words and buffers them
// in a first-word fall-through FIFO with sticky overflow on dropped words.
module uart_rx_word_packer #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_rx_word_packer_if.slave    bus,
  output logic [1:0]              pending_bytes,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic          byte_valid_prev_q, byte_valid_prev_d;
  logic [23:0]   asm_q, asm_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic          byte_accept;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] level_w;
  logic [31:0]   merged_word;

  assign byte_accept = bus.byte_valid && !byte_valid_prev_q;

  assign level_w    = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (level_w == PW'(DEPTH));
  assign fifo_empty = (level_w == '0);
  assign pop        = !fifo_empty && bus.word_ready;

  // Unfilled upper bytes of merged_word are zero because the assembly
  // register is cleared on every push; that gives flush its padding for free.
  always_comb begin
    merged_word = {8'h00, asm_q};
    if (byte_accept) begin
      case (cnt_q)
        2'd0:    merged_word[7:0]   = bus.byte_data;
        2'd1:    merged_word[15:8]  = bus.byte_data;
        2'd2:    merged_word[23:16] = bus.byte_data;
        default: merged_word[31:24] = bus.byte_data;
      endcase
    end
  end

  always_comb begin
    byte_valid_prev_d = bus.byte_valid;
    push_req          = (byte_accept && (cnt_q == 2'd3)) ||
                        (bus.flush && (byte_accept || (cnt_q != 2'd0)));
    if (push_req) begin
      asm_d = '0;
      cnt_d = '0;
    end else begin
      asm_d = merged_word[23:0];
      cnt_d = byte_accept ? (cnt_q + 2'd1) : cnt_q;
    end
  end

  // A full FIFO still accepts a push when the same edge pops the head.
  always_comb begin
    push_ok    = push_req && (!fifo_full || pop);
    overflow_d = overflow_q || (push_req && fifo_full && !pop);
    wr_ptr_d   = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = merged_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_valid_prev_q <= 1'b0;
      asm_q             <= '0;
      cnt_q             <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      overflow_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      byte_valid_prev_q <= byte_valid_prev_d;
      asm_q             <= asm_d;
      cnt_q             <= cnt_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      overflow_q        <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.word_valid = !fifo_empty;
  assign bus.word_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign pending_bytes  = cnt_q;
  assign level          = level_w;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer with DEPTH=4 and hand-computed expectations.
module tb_uart_rx_word_packer;

  logic       clk;
  logic       reset;
  logic [1:0] pending_bytes;
  logic [2:0] level;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_word_packer_if bus ();

  uart_rx_word_packer #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .pending_bytes (pending_bytes),
    .level         (level),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One-cycle byte pulse followed by an idle cycle so the edge detector rearms.
  task automatic send_byte(input logic [7:0] b, input logic do_flush, input logic [1:0] exp_pend);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bus.flush      = do_flush;
    tick();
    chk_val("pending_after_byte", 32'(pending_bytes), 32'(exp_pend));
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_word);
    chk_val(tag, bus.word_data, exp_word);
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask

  logic [31:0] t3_words [4];
  logic [31:0] t5_words [5];

  initial begin
    t3_words[0] = 32'h03020100;
    t3_words[1] = 32'h07060504;
    t3_words[2] = 32'h0B0A0908;
    t3_words[3] = 32'h0F0E0D0C;
    t5_words[0] = 32'h23222120;
    t5_words[1] = 32'h27262524;
    t5_words[2] = 32'h2B2A2928;
    t5_words[3] = 32'h2F2E2D2C;
    t5_words[4] = 32'h33323130;

    do_reset();
    chk_val("rst_word_valid", 32'(bus.word_valid), 32'd0);
    chk_val("rst_word_data", bus.word_data, 32'h0);
    chk_val("rst_pending", 32'(pending_bytes), 32'd0);
    chk_val("rst_level", 32'(level), 32'd0);
    chk_val("rst_overflow", 32'(overflow), 32'd0);

    // Test 1: basic packing.
    send_byte(8'h11, 1'b0, 2'd1);
    send_byte(8'h22, 1'b0, 2'd2);
    send_byte(8'h33, 1'b0, 2'd3);
    send_byte(8'h44, 1'b0, 2'd0);
    chk_val("t1_word_valid", 32'(bus.word_valid), 32'd1);
    chk_val("t1_level", 32'(level), 32'd1);
    pop_check("t1_word", 32'h44332211);
    chk_val("t1_level_after_pop", 32'(level), 32'd0);
    chk_val("t1_valid_after_pop", 32'(bus.word_valid), 32'd0);

    // Test 2: held byte_valid counts once.
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    for (int i = 0; i < 10; i++) tick();
    bus.byte_valid = 1'b0;
    tick();
    chk_val("t2_pending", 32'(pending_bytes), 32'd1);
    chk_val("t2_level", 32'(level), 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_val("t2_flush_level", 32'(level), 32'd1);
    pop_check("t2_flush_word", 32'h0000005A);

    // Test 3: overflow drops the fifth word.
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(8'(w * 4 + b), 1'b0, 2'((b + 1) % 4));
      end
    end
    chk_val("t3_level_full", 32'(level), 32'd4);
    chk_val("t3_overflow", 32'(overflow), 32'd1);
    for (int w = 0; w < 4; w++) pop_check("t3_word", t3_words[w]);
    chk_val("t3_level_empty", 32'(level), 32'd0);
    chk_val("t3_valid_empty", 32'(bus.word_valid), 32'd0);
    chk_val("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Test 4: flush padding and flush combined with an accept.
    do_reset();
    chk_val("t4_overflow_cleared", 32'(overflow), 32'd0);
    send_byte(8'hAA, 1'b0, 2'd1);
    send_byte(8'hBB, 1'b0, 2'd2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_val("t4_pending", 32'(pending_bytes), 32'd0);
    chk_val("t4_level", 32'(level), 32'd1);
    chk_val("t4_word", bus.word_data, 32'h0000BBAA);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_val("t4_noop_flush_level", 32'(level), 32'd1);
    send_byte(8'h01, 1'b0, 2'd1);
    send_byte(8'h02, 1'b0, 2'd2);
    send_byte(8'h03, 1'b0, 2'd3);
    send_byte(8'h04, 1'b1, 2'd0);
    chk_val("t4_complete_flush_level", 32'(level), 32'd2);
    send_byte(8'h77, 1'b1, 2'd0);
    chk_val("t4_accept_flush_level", 32'(level), 32'd3);
    pop_check("t4_pop0", 32'h0000BBAA);
    pop_check("t4_pop1", 32'h04030201);
    pop_check("t4_pop2", 32'h00000077);
    chk_val("t4_level_end", 32'(level), 32'd0);

    // Test 5: push into a full FIFO with a same-edge pop.
    do_reset();
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(8'(8'h20 + w * 4 + b), 1'b0, 2'((b + 1) % 4));
      end
    end
    chk_val("t5_level_full", 32'(level), 32'd4);
    send_byte(8'h30, 1'b0, 2'd1);
    send_byte(8'h31, 1'b0, 2'd2);
    send_byte(8'h32, 1'b0, 2'd3);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h33;
    bus.word_ready = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    bus.word_ready = 1'b0;
    chk_val("t5_level_same", 32'(level), 32'd4);
    chk_val("t5_overflow", 32'(overflow), 32'd0);
    chk_val("t5_pending", 32'(pending_bytes), 32'd0);
    tick();
    for (int w = 1; w < 5; w++) pop_check("t5_word", t5_words[w]);
    chk_val("t5_level_end", 32'(level), 32'd0);

    // Test 6: asynchronous reset mid-word and mid-FIFO.
    for (int b = 0; b < 8; b++) send_byte(8'(b), 1'b0, 2'((b + 1) % 4));
    send_byte(8'hC0, 1'b0, 2'd1);
    send_byte(8'hC1, 1'b0, 2'd2);
    chk_val("t6_level_before", 32'(level), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_val("t6_async_valid", 32'(bus.word_valid), 32'd0);
    chk_val("t6_async_data", bus.word_data, 32'h0);
    chk_val("t6_async_level", 32'(level), 32'd0);
    chk_val("t6_async_pending", 32'(pending_bytes), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    send_byte(8'h01, 1'b0, 2'd1);
    send_byte(8'h02, 1'b0, 2'd2);
    send_byte(8'h03, 1'b0, 2'd3);
    send_byte(8'h04, 1'b0, 2'd0);
    chk_val("t6_level_after", 32'(level), 32'd1);
    pop_check("t6_word", 32'h04030201);

    // byte_valid already high across reset release counts as one byte.
    reset          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h99;
    #2;
    reset = 1'b0;
    tick();
    chk_val("t6_held_through_reset", 32'(pending_bytes), 32'd1);
    tick();
    chk_val("t6_held_no_repeat", 32'(pending_bytes), 32'd1);
    bus.byte_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
Sits directly downstream of the UART byte receiver. It consumes that receiver's byte-complete indication and data byte, and packs bytes little-endian into 32-bit words. Completed words are buffered in a small FIFO and offered to the processor-side consumer over a valid/ready handshake. The block also handles padding of partial words on flush, and flags overflow when the FIFO has no room.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words; power of two, minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
byte_valid  input  1  byte-complete indication from receiver; level or pulse
byte_data  input  8  received byte; stable while byte_valid high
flush  input  1  single-cycle request to emit a partial word, zero-padded
word_valid  output  1  FIFO non-empty; word_data holds the head word
word_data  output  32  head-of-FIFO word
word_ready  input  1  consumer pops the head word when word_valid && word_ready at a clk edge
pending_bytes  output  2  bytes held in the current partial word (0..3)
level  output  $clog2(DEPTH)+1  number of words in the FIFO
overflow  output  1  sticky flag; a word was dropped because the FIFO was full

Behaviour:
- Reset: clk is the system clock; reset is asynchronous, active-high.
- Reset values: all state clears. word_valid=0, word_data=0, pending_bytes=0, level=0, overflow=0.
  - Edge-detect register = 0.
  - Assembly register = 0.
  - FIFO pointers = 0.
  - FIFO storage = 0.
- Byte accept:
  - A byte is accepted at a clk edge where byte_valid=1 and the registered previous byte_valid=0 (rising-edge detect).
  - A held-high byte_valid therefore counts exactly once.
  - byte_valid already high when reset deasserts counts as one byte.
- Packing:
  - The byte at index i (i = pending_bytes before accept) goes to bits [8i+7:8i].
  - Accept with i<3: store the byte, pending_bytes <= i+1.
  - Accept with i==3: form {byte_data, assembly[23:0]} and push it at the same edge; pending_bytes <= 0.
- Latency: word_valid and level update at the same edge the completing byte is accepted, so word_valid is visible in the following cycle. Push and pop are zero-latency register updates.
- FIFO:
  - First-word fall-through: word_data = storage[rd_ptr], driven from registers.
  - Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full = (level==DEPTH); empty = (level==0).
- Pop: occurs at an edge where word_valid && word_ready; rd_ptr advances by one. word_ready while empty is ignored.
- Push while full:
  - Without a same-edge pop, the word is dropped, overflow <= 1, and FIFO contents are unchanged.
  - With a same-edge pop, the pop frees a slot, the push succeeds, level is unchanged, and overflow is not set.
- Overflow clears only on reset.
- Flush:
  - flush with pending_bytes==0 and no byte accepted is a no-op.
  - flush with pending_bytes>0 and no accept pushes the partial word with unfilled upper bytes = 0; pending_bytes <= 0.
  - flush at the same edge as a byte accept: the byte is packed first.
    - If that byte completes the word, exactly one push occurs.
    - Otherwise the padded partial word including the new byte is pushed.
  - A flush-generated push obeys the same full/overflow rules.
- Simultaneous pop and push with the FIFO empty: the pop is ignored (word_valid=0), and the push lands with level=1.
- Reset mid-word or mid-FIFO discards all partial and buffered data immediately (asynchronous).

Test Plan:
1. Bytes 0x11,0x22,0x33,0x44 as one-cycle pulses, word_ready=0 -> pending_bytes steps 1,2,3,0; word_valid=1; word_data=0x44332211; level=1.
2. byte_valid held high 10 cycles with byte_data=0x5A, then low -> exactly one byte accepted; pending_bytes=1; no word pushed.
3. DEPTH=4, word_ready=0, five words 0x03020100, 0x07060504, ... -> level=4; overflow=1; popping yields the first four words in order; the fifth word is absent.
4. Bytes 0xAA,0xBB then flush -> word_data=0x0000BBAA; pending_bytes=0. A second flush alone causes no push and level stays 1.
5. FIFO full, word_ready=1 at the same edge the 4th byte completes a word -> level stays 4; overflow=0; head advances; the new word is at the tail.
6. Two bytes accepted plus two words buffered, then reset asserted mid-cycle -> outputs clear immediately to reset values. After release, bytes 0x01..0x04 -> 0x04030201.
